tb_cmd_sequencer: RTL

//   Testbench command scheduler that sits between the scenario command source and the SET/WAIT/CHECK units.

---
 rtl/tb_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/tb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cmd_sequencer
//   Command scheduler between a scenario command source and the SET / WAIT /
//   CHECK units. Takes one encoded command at a time, drives the matching unit
//   select with the latched argument until that unit reports done, then pulses
//   an acknowledge. CHECK failures (and WAIT timeouts when enabled) land in a
//   sticky error register that keeps the first error until cleared.
//
//   Optional feature macro: TB_SEQ_TIMEOUT_EN
//     defined   : per-command WAIT timeout counter (i_timeout cycles, 0 = none)
//     undefined : WAIT blocks until i_wait_done, i_timeout ignored
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   i_cmd_valid       command present
//   o_cmd_ready       sequencer idle and out of reset
//   i_cmd_op          0=SET 1=WTR 2=WTF 3=CHK
//   i_cmd_arg         command argument
//   i_timeout         WAIT timeout in cycles, 0 = none
//   o_sel_set/wait/check  unit selects (level, held while busy)
//   o_wait_fall       1 = wait for falling edge (WTF), 0 = rising (WTR)
//   o_arg             argument latched at accept, held until next accept
//   i_set_done, i_wait_done, i_check_done  unit completion strobes
//   i_check_ok        CHECK result, sampled with i_check_done
//   o_ack             one-cycle completion pulse
//   o_busy            command in flight
//   o_err, o_err_code sticky error flag / first error code (1 CHK, 2 timeout)
//   i_clr_err         clear error register
// ---------------------------------------------------------------------------
module tb_cmd_sequencer #(
  parameter int unsigned ARG_W     = 32,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_op,
  input  logic [ARG_W-1:0]     i_cmd_arg,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  output logic                 o_sel_set,
  output logic                 o_sel_wait,
  output logic                 o_sel_check,
  output logic                 o_wait_fall,
  output logic [ARG_W-1:0]     o_arg,
  input  logic                 i_set_done,
  input  logic                 i_wait_done,
  input  logic                 i_check_done,
  input  logic                 i_check_ok,
  output logic                 o_ack,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [1:0]           o_err_code,
  input  logic                 i_clr_err
);

  localparam logic [1:0] OP_SET = 2'd0;
  localparam logic [1:0] OP_WTR = 2'd1;
  localparam logic [1:0] OP_WTF = 2'd2;
  localparam logic [1:0] OP_CHK = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [ARG_W-1:0]   arg_q, arg_d;
  logic               fall_q, fall_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic               accept;
  logic               is_wait_op;
  logic               done_sel;
  logic               expire;
  logic               finish;
  logic [1:0]         new_code;

  // Command handshake and completion qualifiers
  assign accept     = i_cmd_valid & (state_q == ST_IDLE);
  assign is_wait_op = (op_q == OP_WTR) | (op_q == OP_WTF);

  // Only the done strobe of the unit currently selected ends the command
  always_comb begin
    done_sel = 1'b0;
    case (op_q)
      OP_SET:  done_sel = i_set_done;
      OP_WTR:  done_sel = i_wait_done;
      OP_WTF:  done_sel = i_wait_done;
      OP_CHK:  done_sel = i_check_done;
      default: done_sel = 1'b0;
    endcase
  end

`ifdef TB_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Counter value 0 means "no timeout"; expiry is the BUSY edge at which it
  // would step from 1 to 0, so i_timeout=N allows exactly N BUSY cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = i_timeout;
    end else if (state_q == ST_BUSY) begin
      if (finish) begin
        cnt_d = '0;
      end else if (is_wait_op && (cnt_q != '0)) begin
        cnt_d = cnt_q - TIMEOUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (state_q == ST_BUSY) & is_wait_op & (cnt_q == TIMEOUT_W'(1));
`else
  logic unused_timeout;
  assign unused_timeout = ^i_timeout;
  assign expire         = 1'b0;
`endif

  assign finish = (state_q == ST_BUSY) & (done_sel | expire);

  // Error raised by the command finishing this cycle; done beats expiry
  always_comb begin
    new_code = ERR_NONE;
    if (state_q == ST_BUSY) begin
      if (done_sel) begin
        if ((op_q == OP_CHK) && !i_check_ok) begin
          new_code = ERR_CHK;
        end
      end else if (expire) begin
        new_code = ERR_TMO;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (finish) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state and latched op only
  always_comb begin
    o_cmd_ready = (state_q == ST_IDLE) & ~rst;
    o_busy      = (state_q == ST_BUSY);
    o_ack       = (state_q == ST_ACK);
    o_sel_set   = 1'b0;
    o_sel_wait  = 1'b0;
    o_sel_check = 1'b0;
    if (state_q == ST_BUSY) begin
      case (op_q)
        OP_SET:  o_sel_set   = 1'b1;
        OP_WTR:  o_sel_wait  = 1'b1;
        OP_WTF:  o_sel_wait  = 1'b1;
        OP_CHK:  o_sel_check = 1'b1;
        default: o_sel_set   = 1'b0;
      endcase
    end
  end

  // Command latch: argument and edge direction persist past ACK
  always_comb begin
    op_d   = op_q;
    arg_d  = arg_q;
    fall_d = fall_q;
    if (accept) begin
      op_d   = i_cmd_op;
      arg_d  = i_cmd_arg;
      fall_d = (i_cmd_op == OP_WTF);
    end
  end

  // Sticky error: first error wins unless cleared in the same cycle
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if ((new_code != ERR_NONE) && (!err_q || i_clr_err)) begin
      err_d  = 1'b1;
      code_d = new_code;
    end else if (i_clr_err) begin
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_SET;
      arg_q  <= '0;
      fall_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      op_q   <= op_d;
      arg_q  <= arg_d;
      fall_q <= fall_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign o_arg       = arg_q;
  assign o_wait_fall = fall_q;
  assign o_err       = err_q;
  assign o_err_code  = code_q;

endmodule
